// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encoding and RISC-V OP / OP-IMM decode constants.
package alu_pkg;

    localparam int SELECT_WIDTH = 4;

    typedef enum logic [SELECT_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_MUL = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8
    } ALUOp;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [11:0] IMM_ALL_ONES = 12'hFFF;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one OP / OP-IMM instruction into ALU select and operands.
module alu_decode
    import alu_pkg::*;
#(
    parameter int dataWidth = 32
) (
    input  logic [31:0]          instr,
    input  logic [dataWidth-1:0] rs1Data,
    input  logic [dataWidth-1:0] rs2Data,
    output ALUOp                 op,
    output logic [dataWidth-1:0] opA,
    output logic [dataWidth-1:0] opB,
    output logic                 illegal
);

    logic [6:0]           opcode;
    logic [6:0]           funct7;
    logic [2:0]           funct3;
    logic [dataWidth-1:0] imm_sext;
    logic [dataWidth-1:0] shamt_reg;
    logic [dataWidth-1:0] shamt_imm;
    logic                 unused_rd;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_sext  = {{(dataWidth-12){instr[31]}}, instr[31:20]};
    assign shamt_reg = {{(dataWidth-5){1'b0}}, rs2Data[4:0]};
    assign shamt_imm = {{(dataWidth-5){1'b0}}, instr[24:20]};
    assign unused_rd = ^instr[11:7];

    // Opcode/funct decode; anything not matched below stays illegal.
    always_comb begin
        op      = ALU_ADD;
        opA     = rs1Data;
        opB     = rs2Data;
        illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            op = ALU_ADD; illegal = 1'b0;
                        end else if (funct7 == F7_SUB) begin
                            op = ALU_SUB; illegal = 1'b0;
                        end else if (funct7 == F7_MUL) begin
                            op = ALU_MUL; illegal = 1'b0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    F3_AND: begin op = ALU_AND; illegal = 1'b0; end
                    F3_OR:  begin op = ALU_OR;  illegal = 1'b0; end
                    F3_XOR: begin op = ALU_XOR; illegal = 1'b0; end
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            op = ALU_SLL; opB = shamt_reg; illegal = 1'b0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    F3_SRL: begin
                        if (funct7 == F7_BASE) begin
                            op = ALU_SRL; opB = shamt_reg; illegal = 1'b0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                opB = imm_sext;
                case (funct3)
                    F3_ADD_SUB: begin op = ALU_ADD; illegal = 1'b0; end
                    F3_AND:     begin op = ALU_AND; illegal = 1'b0; end
                    F3_OR:      begin op = ALU_OR;  illegal = 1'b0; end
                    F3_XOR: begin
                        // XORI with all-ones immediate is bitwise NOT of rs1
                        if (instr[31:20] == IMM_ALL_ONES) begin
                            op = ALU_NOT; opB = {dataWidth{1'b0}}; illegal = 1'b0;
                        end else begin
                            op = ALU_XOR; illegal = 1'b0;
                        end
                    end
                    F3_SLL: begin
                        if (funct7 == F7_BASE) begin
                            op = ALU_SLL; opB = shamt_imm; illegal = 1'b0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    F3_SRL: begin
                        if (funct7 == F7_BASE) begin
                            op = ALU_SRL; opB = shamt_imm; illegal = 1'b0;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue front end: accepts an instruction, drives the ALU for a fixed latency,
// captures its result and returns it with the destination register.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4,
    parameter int aluLatency  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instrValid,
    output logic                   instrReady,
    input  logic [31:0]            instr,
    input  logic [dataWidth-1:0]   rs1Data,
    input  logic [dataWidth-1:0]   rs2Data,
    output logic [dataWidth-1:0]   inputA,
    output logic [dataWidth-1:0]   inputB,
    output logic [selectWidth-1:0] ALUSelect,
    input  logic [dataWidth-1:0]   dataOut,
    input  logic [dataWidth-1:0]   dataOutHigh,
    output logic                   resultValid,
    input  logic                   resultReady,
    output logic [dataWidth-1:0]   result,
    output logic [dataWidth-1:0]   resultHigh,
    output logic [4:0]             rd,
    output logic                   illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(aluLatency);

    ALUOp                 dec_op;
    logic [dataWidth-1:0] dec_a;
    logic [dataWidth-1:0] dec_b;
    logic                 dec_illegal;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 instr_ready_q, instr_ready_d;
    logic                 result_valid_q, result_valid_d;
    logic                 illegal_q, illegal_d;
    logic [dataWidth-1:0] input_a_q, input_a_d;
    logic [dataWidth-1:0] input_b_q, input_b_d;
    logic [selectWidth-1:0] sel_q, sel_d;
    logic [dataWidth-1:0] result_q, result_d;
    logic [dataWidth-1:0] result_high_q, result_high_d;
    logic [4:0]           rd_q, rd_d;

    alu_decode #(.dataWidth(dataWidth)) u_decode (
        .instr   (instr),
        .rs1Data (rs1Data),
        .rs2Data (rs2Data),
        .op      (dec_op),
        .opA     (dec_a),
        .opB     (dec_b),
        .illegal (dec_illegal)
    );

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        instr_ready_d  = instr_ready_q;
        result_valid_d = result_valid_q;
        illegal_d      = illegal_q;
        input_a_d      = input_a_q;
        input_b_d      = input_b_q;
        sel_d          = sel_q;
        result_d       = result_q;
        result_high_d  = result_high_q;
        rd_d           = rd_q;
        case (state_q)
            S_IDLE: begin
                instr_ready_d = 1'b1;
                if (instr_ready_q && instrValid) begin
                    instr_ready_d = 1'b0;
                    rd_d          = instr[11:7];
                    illegal_d     = dec_illegal;
                    if (dec_illegal) begin
                        // ALU inputs keep their previous values
                        result_d      = {dataWidth{1'b0}};
                        result_high_d = {dataWidth{1'b0}};
                        state_d       = S_RESP;
                    end else begin
                        input_a_d = dec_a;
                        input_b_d = dec_b;
                        sel_d     = selectWidth'(dec_op);
                        cnt_d     = LAT_INIT;
                        state_d   = S_EXEC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_q == 3'd0) begin
                    result_d       = dataOut;
                    result_high_d  = dataOutHigh;
                    result_valid_d = 1'b1;
                    state_d        = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                // An illegal instruction arrives here with valid still low
                if (!result_valid_q) begin
                    result_valid_d = 1'b1;
                end else if (resultReady) begin
                    result_valid_d = 1'b0;
                    instr_ready_d  = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d        = S_IDLE;
                instr_ready_d  = 1'b0;
                result_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 3'd0;
            instr_ready_q  <= 1'b0;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            input_a_q      <= {dataWidth{1'b0}};
            input_b_q      <= {dataWidth{1'b0}};
            sel_q          <= selectWidth'(ALU_ADD);
            result_q       <= {dataWidth{1'b0}};
            result_high_q  <= {dataWidth{1'b0}};
            rd_q           <= 5'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            instr_ready_q  <= instr_ready_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
            input_a_q      <= input_a_d;
            input_b_q      <= input_b_d;
            sel_q          <= sel_d;
            result_q       <= result_d;
            result_high_q  <= result_high_d;
            rd_q           <= rd_d;
        end
    end

    assign instrReady  = instr_ready_q;
    assign resultValid = result_valid_q;
    assign illegal     = illegal_q;
    assign inputA      = input_a_q;
    assign inputB      = input_b_q;
    assign ALUSelect   = sel_q;
    assign result      = result_q;
    assign resultHigh  = result_high_q;
    assign rd          = rd_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed vector table, hand sequences, and random
// instructions checked against a behavioural reference model, with a 1-cycle ALU.
module tb_alu_dispatch;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instrValid = 1'b0;
    logic        instrReady;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs1Data = 32'h0;
    logic [31:0] rs2Data = 32'h0;
    logic [31:0] inputA, inputB;
    logic [3:0]  ALUSelect;
    logic [31:0] dataOut = 32'h0;
    logic [31:0] dataOutHigh = 32'h0;
    logic        resultValid;
    logic        resultReady = 1'b0;
    logic [31:0] result, resultHigh;
    logic [4:0]  rd;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    string cur_tag = "init";
    int cur_idx = 0;

    alu_dispatch #(.dataWidth(32), .selectWidth(4), .aluLatency(LAT)) dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
        .instr(instr), .rs1Data(rs1Data), .rs2Data(rs2Data),
        .inputA(inputA), .inputB(inputB), .ALUSelect(ALUSelect),
        .dataOut(dataOut), .dataOutHigh(dataOutHigh),
        .resultValid(resultValid), .resultReady(resultReady),
        .result(result), .resultHigh(resultHigh), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Simple ALU with one cycle of latency; shifts use the full operand B.
    function automatic logic [63:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0: return {32'h0, a + b};
            4'd1: return {32'h0, a - b};
            4'd2: return 64'(a) * 64'(b);
            4'd3: return {32'h0, a & b};
            4'd4: return {32'h0, a | b};
            4'd5: return {32'h0, a ^ b};
            4'd6: return {32'h0, ~a};
            4'd7: return {32'h0, a << b};
            4'd8: return {32'h0, a >> b};
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    always @(posedge clk) {dataOutHigh, dataOut} <= alu_fn(ALUSelect, inputA, inputB);

    typedef struct {
        logic        legal;
        logic [31:0] res;
        logic [31:0] hi;
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    // Reference: what the instruction means architecturally.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [63:0] p;
        logic [31:0] imm;
        logic [4:0]  sh;
        e.legal = 1'b0; e.res = 32'h0; e.hi = 32'h0; e.sel = 0; e.a = r1; e.b = 32'h0;
        imm = {{20{i[31]}}, i[31:20]};
        if (i[6:0] == 7'b0110011) begin
            sh = r2[4:0];
            e.b = r2;
            case (i[14:12])
                3'd0: if (i[31:25] == 7'h00) begin e.legal = 1'b1; e.sel = 0; e.res = r1 + r2; end
                      else if (i[31:25] == 7'h20) begin e.legal = 1'b1; e.sel = 1; e.res = r1 - r2; end
                      else if (i[31:25] == 7'h01) begin
                          p = 64'(r1) * 64'(r2);
                          e.legal = 1'b1; e.sel = 2; e.res = p[31:0]; e.hi = p[63:32];
                      end
                3'd7: begin e.legal = 1'b1; e.sel = 3; e.res = r1 & r2; end
                3'd6: begin e.legal = 1'b1; e.sel = 4; e.res = r1 | r2; end
                3'd4: begin e.legal = 1'b1; e.sel = 5; e.res = r1 ^ r2; end
                3'd1: if (i[31:25] == 7'h00) begin e.legal = 1'b1; e.sel = 7; e.b = 32'(sh); e.res = r1 << sh; end
                3'd5: if (i[31:25] == 7'h00) begin e.legal = 1'b1; e.sel = 8; e.b = 32'(sh); e.res = r1 >> sh; end
                default: e.legal = 1'b0;
            endcase
        end else if (i[6:0] == 7'b0010011) begin
            sh = i[24:20];
            e.b = imm;
            case (i[14:12])
                3'd0: begin e.legal = 1'b1; e.sel = 0; e.res = r1 + imm; end
                3'd7: begin e.legal = 1'b1; e.sel = 3; e.res = r1 & imm; end
                3'd6: begin e.legal = 1'b1; e.sel = 4; e.res = r1 | imm; end
                3'd4: if (i[31:20] == 12'hFFF) begin e.legal = 1'b1; e.sel = 6; e.b = 32'h0; e.res = ~r1; end
                      else begin e.legal = 1'b1; e.sel = 5; e.res = r1 ^ imm; end
                3'd1: if (i[31:25] == 7'h00) begin e.legal = 1'b1; e.sel = 7; e.b = 32'(sh); e.res = r1 << sh; end
                3'd5: if (i[31:25] == 7'h00) begin e.legal = 1'b1; e.sel = 8; e.b = 32'(sh); e.res = r1 >> sh; end
                default: e.legal = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
        return {f7, 5'd2, 5'd1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] d);
        return {imm, 5'd1, f3, d, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] %s: got %h expected %h", cur_tag, cur_idx, nm, act, exp);
        end
    endtask

    // Issue one instruction, check its response, hold the result `hold` cycles, then accept it.
    task automatic txn(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                       input exp_t e, input int hold);
        logic [31:0] pa, pb, pr;
        logic [3:0]  ps;
        int n;
        int lat;
        pa = inputA; pb = inputB; ps = ALUSelect;
        n = 0;
        while (!instrReady && n < 20) begin @(posedge clk); #1; n++; end
        chk("instrReady_before", 64'(instrReady), 64'd1);
        instr = i; rs1Data = r1; rs2Data = r2; instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        instr = $urandom; rs1Data = $urandom; rs2Data = $urandom;
        lat = 0;
        while (!resultValid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), e.legal ? 64'(LAT + 1) : 64'd1);
        chk("illegal", 64'(illegal), 64'(!e.legal));
        chk("rd", 64'(rd), 64'(i[11:7]));
        chk("result", 64'(result), 64'(e.res));
        chk("resultHigh", 64'(resultHigh), 64'(e.hi));
        chk("instrReady_busy", 64'(instrReady), 64'd0);
        if (e.legal) begin
            chk("ALUSelect", 64'(ALUSelect), 64'(e.sel));
            chk("inputA", 64'(inputA), 64'(e.a));
            chk("inputB", 64'(inputB), 64'(e.b));
        end else begin
            chk("ALUSelect_held", 64'(ALUSelect), 64'(ps));
            chk("inputA_held", 64'(inputA), 64'(pa));
            chk("inputB_held", 64'(inputB), 64'(pb));
        end
        pr = result;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resultValid), 64'd1);
            chk("hold_instrReady", 64'(instrReady), 64'd0);
            chk("hold_result", 64'(result), 64'(pr));
        end
        resultReady = 1'b1;
        @(posedge clk); #1;
        resultReady = 1'b0;
        chk("valid_drop", 64'(resultValid), 64'd0);
        chk("instrReady_after", 64'(instrReady), 64'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_instrReady", 64'(instrReady), 64'd0);
        chk("rst_resultValid", 64'(resultValid), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_inputA", 64'(inputA), 64'd0);
        chk("rst_inputB", 64'(inputB), 64'd0);
        chk("rst_ALUSelect", 64'(ALUSelect), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_resultHigh", 64'(resultHigh), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        legal;
        logic [31:0] res;
        int          sel;
        logic [31:0] b;
    } vec_t;

    vec_t vt[13];

    initial begin
        exp_t e;
        logic [31:0] i, r1, r2, rnd;
        int k;

        vt[0]  = '{rtype(7'h00, 3'd0, 5'd5),  32'd8,        32'd7,        1'b1, 32'h0000000F, 0, 32'd7};
        vt[1]  = '{rtype(7'h20, 3'd0, 5'd6),  32'd3,        32'd7,        1'b1, 32'hFFFFFFFC, 1, 32'd7};
        vt[2]  = '{rtype(7'h01, 3'd0, 5'd7),  32'd7,        32'd7,        1'b1, 32'h00000031, 2, 32'd7};
        vt[3]  = '{itype(12'hFFF, 3'd4, 5'd8), 32'h12345678, 32'h0,       1'b1, 32'hEDCBA987, 6, 32'h0};
        vt[4]  = '{rtype(7'h00, 3'd1, 5'd9),  32'hA5A5A5A5, 32'd32,       1'b1, 32'hA5A5A5A5, 7, 32'h0};
        vt[5]  = '{itype(12'h01F, 3'd5, 5'd10), 32'h80000000, 32'h0,      1'b1, 32'h00000001, 8, 32'd31};
        vt[6]  = '{{20'h12345, 5'd11, 7'b0110111}, 32'd1,   32'd2,        1'b0, 32'h0, 0, 32'h0};
        vt[7]  = '{rtype(7'h00, 3'd7, 5'd12), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'h00F000F0, 3, 32'h0FF00FF0};
        vt[8]  = '{itype(12'hF00, 3'd6, 5'd13), 32'h0000000F, 32'h0,      1'b1, 32'hFFFFFF0F, 4, 32'hFFFFFF00};
        vt[9]  = '{rtype(7'h21, 3'd0, 5'd14), 32'd5,        32'd6,        1'b0, 32'h0, 0, 32'h0};
        vt[10] = '{itype(12'h41F, 3'd1, 5'd15), 32'd5,      32'd6,        1'b0, 32'h0, 0, 32'h0};
        vt[11] = '{rtype(7'h00, 3'd0, 5'd0),  32'd1,        32'd2,        1'b1, 32'h00000003, 0, 32'd2};
        vt[12] = '{itype(12'h800, 3'd0, 5'd16), 32'h0,      32'h0,        1'b1, 32'hFFFFF800, 0, 32'hFFFFF800};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cur_tag = "reset";
        chk_reset_values();
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_instrReady", 64'(instrReady), 64'd1);

        // Directed vector table
        cur_tag = "tbl";
        for (int v = 0; v < 13; v++) begin
            cur_idx = v;
            e.legal = vt[v].legal; e.res = vt[v].res; e.hi = 32'h0;
            e.sel = vt[v].sel; e.a = vt[v].rs1; e.b = vt[v].b;
            txn(vt[v].instr, vt[v].rs1, vt[v].rs2, e, 0);
        end

        // Back-pressure: result held 5 cycles
        cur_tag = "bp"; cur_idx = 0;
        e = model(rtype(7'h20, 3'd0, 5'd3), 32'd100, 32'd1);
        txn(rtype(7'h20, 3'd0, 5'd3), 32'd100, 32'd1, e, 5);

        // Reset while in EXEC abandons the instruction
        cur_tag = "rst_exec";
        instr = rtype(7'h00, 3'd0, 5'd4); rs1Data = 32'd11; rs2Data = 32'd22;
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        chk("exec_instrReady", 64'(instrReady), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_values();
        for (int c = 0; c < 4; c++) begin
            cur_idx = c;
            @(posedge clk); #1;
            chk("no_result_after_reset", 64'(resultValid), 64'd0);
        end
        chk("ready_after_reset", 64'(instrReady), 64'd1);

        // Random instructions against the reference model
        cur_tag = "rnd";
        for (int n = 0; n < 80; n++) begin
            cur_idx = n;
            k = $urandom_range(0, 3);
            rnd = $urandom;
            case (k)
                0: begin
                    i = {rnd[31:7], 7'b0110011};
                    case (rnd[1:0])
                        2'd0: i[31:25] = 7'h00;
                        2'd1: i[31:25] = 7'h20;
                        2'd2: i[31:25] = 7'h01;
                        default: i[31:25] = rnd[31:25];
                    endcase
                end
                1: begin
                    i = {rnd[31:7], 7'b0010011};
                    if (rnd[0]) i[31:25] = 7'h00;
                end
                2: i = {12'hFFF, rnd[19:15], 3'b100, rnd[11:7], 7'b0010011};
                default: i = rnd;
            endcase
            r1 = $urandom;
            r2 = (n % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            e = model(i, r1, r2);
            txn(i, r1, r2, e, n % 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
